shr_harness: RTL and testbench
==============================

SHR_HARNESS -- requirements
Module: shr_harness

Interface
- REQ-001: Parameter DIN_N, default 256: width of serial-in shift register and parallel din bus; legal range 2..4096.
- REQ-002: Parameter DOUT_N, default 256: width of parallel dout bus and serial-out shift register; legal range 2..4096.
- REQ-003: Parameter CAP_DLY, default 0: clock cycles between a load event and the dout capture; legal range 0..15.
- REQ-004: Parameter AUTO_STB, default 0: 0 = load on stb; 1 = load generated internally every DIN_N cycles, stb ignored.
- REQ-005: clk  input  1  single clock; all state updates on its rising edge.
- REQ-006: rst_n  input  1  asynchronous, active-low reset.
- REQ-007: di  input  1  serial data in.
- REQ-008: stb  input  1  load strobe, used only when AUTO_STB=0.
- REQ-009: do  output  1  serial data out, equal to dout_shr[DOUT_N-1].
- REQ-010: din  output  DIN_N  parallel word driven to the ROI.
- REQ-011: dout  input  DOUT_N  parallel word returned from the ROI.
- REQ-012: busy  output  1  high while a capture is pending (state WAIT).
- REQ-013: cap_done  output  1  single-cycle pulse in the cycle after a capture.

Function
- REQ-014: Every cycle din_shr shifts left by 1 with di entering bit 0.
- REQ-015: Every cycle without a capture, dout_shr shifts left by 1 with din_shr[DIN_N-1] entering bit 0.
- REQ-016: Load event: stb=1 (AUTO_STB=0), or bit_cnt==DIN_N-1 (AUTO_STB=1).
- REQ-017: On a load event din takes the pre-edge value of din_shr; din is otherwise held.
- REQ-018: bit_cnt is $clog2(DIN_N) bits wide, increments every cycle, and clears to 0 on a load event; it is maintained in both modes.
- REQ-019: FSM states: IDLE and WAIT. With CAP_DLY=0, WAIT is never entered and capture occurs on the same edge as the load.
- REQ-020: With CAP_DLY>0, a load in IDLE sets wait_cnt=CAP_DLY-1 and moves to WAIT.
- REQ-021: In WAIT, wait_cnt decrements each cycle; at wait_cnt==0 the capture fires and the FSM returns to IDLE.
- REQ-022: Capture: dout_shr takes dout in place of the shift for that cycle.
- REQ-023: A load arriving in WAIT updates din, reloads wait_cnt=CAP_DLY-1, and stays in WAIT; exactly one capture follows the last load.
- REQ-024: A load coinciding with the wait_cnt==0 capture edge performs that capture, reloads wait_cnt and stays in WAIT.
- REQ-025: cap_done is registered and asserts for exactly one cycle after each capture edge.
- REQ-026: busy is high exactly while the FSM is in WAIT.

Reset
- REQ-027: While rst_n=0: din_shr, dout_shr, din, bit_cnt and wait_cnt are 0; FSM is IDLE; do, busy and cap_done are 0.
- REQ-028: Reset asserted mid-WAIT aborts the pending capture; no cap_done follows reset release.
- REQ-029: The first load event after release requires a full DIN_N cycles in AUTO_STB=1.

Configuration
- REQ-030: With macro SHR_PARITY_EN defined, output port par (1 bit) exists: it loads even parity (XOR-reduce) of dout on each capture edge, is held otherwise, and resets to 0.
- REQ-031: Without SHR_PARITY_EN, port par and its logic are absent and all other behaviour is identical.

Verification
- REQ-032: DIN_N=DOUT_N=8, CAP_DLY=0: shift di=1,0,1,1,0,0,1,0, then stb -> din=8'hB2 on the stb edge; dout=8'h5A on that edge -> do yields 0,1,0,1,1,0,1,0 over the next 8 cycles.
- REQ-033: CAP_DLY=3, stb at cycle 10 -> busy high cycles 11-13, capture on the edge ending cycle 13, cap_done high cycle 14 only.
- REQ-034: CAP_DLY=3, stb at cycle 10 and again at cycle 12 -> single capture on the edge ending cycle 15, single cap_done pulse at cycle 16.
- REQ-035: AUTO_STB=1, DIN_N=8, stb held 1 -> load edges exactly at cycles 8, 16, 24 after reset release.
- REQ-036: rst_n pulsed low during WAIT (CAP_DLY=5) -> all outputs 0 immediately; no cap_done afterwards.
- REQ-037: SHR_PARITY_EN defined, dout=8'h07 captured -> par=1; dout=8'h03 captured -> par=0.

Source files
------------

// File: rtl/shr_harness.sv
// Serial-in/parallel-out and parallel-in/serial-out shift harness around a ROI.
// Optional registered dout parity on port par when SHR_PARITY_EN is defined.
module shr_harness #(
  parameter int DIN_N    = 256,
  parameter int DOUT_N   = 256,
  parameter int CAP_DLY  = 0,
  parameter int AUTO_STB = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              di,
  input  logic              stb,
  output logic              sdo,
  output logic [DIN_N-1:0]  din,
  input  logic [DOUT_N-1:0] dout,
  output logic              busy,
  output logic              cap_done
`ifdef SHR_PARITY_EN
  ,
  output logic              par
`endif
);

  localparam int CW = $clog2(DIN_N);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIN_N - 1);
  localparam logic [3:0] WAIT_LD =
    4'((CAP_DLY > 0) ? CAP_DLY - 1 : 0);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DIN_N-1:0]  din_shr;
  logic [DOUT_N-1:0] dout_shr;
  logic [CW-1:0]     bit_cnt;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_nxt;
  logic              load;
  logic              cap;

  always_comb begin
    load = stb;
    if (AUTO_STB != 0) load = (bit_cnt == CNT_LAST);
  end

  // Zero delay captures on the load edge and never leaves IDLE.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    cap       = 1'b0;
    if (CAP_DLY == 0) begin
      cap = load;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            state_nxt = ST_WAIT;
            wait_nxt  = WAIT_LD;
          end
        end
        ST_WAIT: begin
          cap = (wait_cnt == 4'd0);
          if (load) begin
            wait_nxt = WAIT_LD;
          end else if (cap) begin
            state_nxt = ST_IDLE;
          end else begin
            wait_nxt = wait_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      din_shr  <= '0;
      dout_shr <= '0;
      din      <= '0;
      cap_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      bit_cnt  <= load ? '0 : bit_cnt + 1'b1;
      din_shr  <= {din_shr[DIN_N-2:0], di};
      if (cap) dout_shr <= dout;
      else dout_shr <= {dout_shr[DOUT_N-2:0], din_shr[DIN_N-1]};
      if (load) din <= din_shr;
      cap_done <= cap;
    end
  end

`ifdef SHR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else if (cap) par <= ^dout;
  end
`endif

  assign sdo  = dout_shr[DOUT_N-1];
  assign busy = (state == ST_WAIT);

endmodule

// File: tb/tb_shr_harness.sv
// Directed bench for shr_harness: four configurations share one stimulus.
// An edge-history model predicts every output; literals pin the model.
module tb_shr_harness;

  logic       clk;
  logic       rst_n;
  logic       di;
  logic       stb;
  logic [7:0] dout;

  logic       so0, so3, so5, soa;
  logic [7:0] din0, din3, din5, dina;
  logic       bz0, bz3, bz5, bza;
  logic       cd0, cd3, cd5, cda;
`ifdef SHR_PARITY_EN
  logic       pr0, pr3, pr5, pra;
`endif

  int vectors = 0;
  int errs    = 0;
  int n       = 0;
  bit running = 1'b1;

  bit         di_at   [256];
  bit         stb_at  [256];
  logic [7:0] dout_at [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shr_harness #(.DIN_N(8), .DOUT_N(8), .CAP_DLY(0), .AUTO_STB(0)) u0 (
    .clk(clk), .rst_n(rst_n), .di(di), .stb(stb), .sdo(so0),
    .din(din0), .dout(dout), .busy(bz0), .cap_done(cd0)
`ifdef SHR_PARITY_EN
    , .par(pr0)
`endif
  );

  shr_harness #(.DIN_N(8), .DOUT_N(8), .CAP_DLY(3), .AUTO_STB(0)) u3 (
    .clk(clk), .rst_n(rst_n), .di(di), .stb(stb), .sdo(so3),
    .din(din3), .dout(dout), .busy(bz3), .cap_done(cd3)
`ifdef SHR_PARITY_EN
    , .par(pr3)
`endif
  );

  shr_harness #(.DIN_N(8), .DOUT_N(8), .CAP_DLY(5), .AUTO_STB(0)) u5 (
    .clk(clk), .rst_n(rst_n), .di(di), .stb(stb), .sdo(so5),
    .din(din5), .dout(dout), .busy(bz5), .cap_done(cd5)
`ifdef SHR_PARITY_EN
    , .par(pr5)
`endif
  );

  shr_harness #(.DIN_N(8), .DOUT_N(8), .CAP_DLY(2), .AUTO_STB(1)) ua (
    .clk(clk), .rst_n(rst_n), .di(di), .stb(stb), .sdo(soa),
    .din(dina), .dout(dout), .busy(bza), .cap_done(cda)
`ifdef SHR_PARITY_EN
    , .par(pra)
`endif
  );

  // Edge history since the last reset release; edge 1 is the first one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 0;
    end else begin
      n <= n + 1;
      di_at[n+1]   <= di;
      stb_at[n+1]  <= stb;
      dout_at[n+1] <= dout;
    end
  end

  function automatic bit is_load(int a, int m);
    if (m < 1) return 1'b0;
    if (a != 0) return (m % 8) == 0;
    return stb_at[m];
  endfunction

  // A capture lands C edges after a load not followed by another load.
  function automatic bit is_cap(int a, int c, int m);
    if (m < 1) return 1'b0;
    if (c == 0) return is_load(a, m);
    if (!is_load(a, m - c)) return 1'b0;
    for (int k = m - c + 1; k < m; k++)
      if (is_load(a, k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int a, int c);
    if (c == 0) return 1'b0;
    for (int k = n - c + 1; k <= n; k++)
      if (is_load(a, k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_din(int a);
    logic [7:0] v;
    v = '0;
    for (int m = n; m >= 1; m--) begin
      if (is_load(a, m)) begin
        for (int k = 0; k < 8; k++)
          if (m - 1 - k >= 1) v[k] = di_at[m-1-k];
        return v;
      end
    end
    return v;
  endfunction

  // Serial out: recent capture word MSB first, else di delayed 15 edges.
  function automatic logic exp_do(int a, int c);
    logic [7:0] w;
    for (int m = n; m >= 1 && m > n - 8; m--) begin
      if (is_cap(a, c, m)) begin
        w = dout_at[m];
        return w[7-(n-m)];
      end
    end
    if (n - 15 >= 1) return di_at[n-15];
    return 1'b0;
  endfunction

`ifdef SHR_PARITY_EN
  function automatic logic exp_par(int a, int c);
    for (int m = n; m >= 1; m--)
      if (is_cap(a, c, m)) return ^dout_at[m];
    return 1'b0;
  endfunction
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, n);
    end
  endtask

  task automatic check_inst(string tag, int a, int c, logic so,
                            logic [7:0] dn, logic bz, logic cd
`ifdef SHR_PARITY_EN
                            , logic pr
`endif
                            );
    chk({tag, ".do"}, 32'(so), 32'(exp_do(a, c)));
    chk({tag, ".din"}, 32'(dn), 32'(exp_din(a)));
    chk({tag, ".busy"}, 32'(bz), 32'(exp_busy(a, c)));
    chk({tag, ".cap_done"}, 32'(cd), 32'(is_cap(a, c, n)));
`ifdef SHR_PARITY_EN
    chk({tag, ".par"}, 32'(pr), 32'(exp_par(a, c)));
`endif
  endtask

  always @(negedge clk) begin
    if (running) begin
`ifdef SHR_PARITY_EN
      check_inst("u0", 0, 0, so0, din0, bz0, cd0, pr0);
      check_inst("u3", 0, 3, so3, din3, bz3, cd3, pr3);
      check_inst("u5", 0, 5, so5, din5, bz5, cd5, pr5);
      check_inst("ua", 1, 2, soa, dina, bza, cda, pra);
`else
      check_inst("u0", 0, 0, so0, din0, bz0, cd0);
      check_inst("u3", 0, 3, so3, din3, bz3, cd3);
      check_inst("u5", 0, 5, so5, din5, bz5, cd5);
      check_inst("ua", 1, 2, soa, dina, bza, cda);
`endif
    end
  end

  task automatic step(input logic d, input logic s,
                      input logic [7:0] v);
    di   = d;
    stb  = s;
    dout = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  pat;
  logic [7:0]  so_seq;
  logic [4:0]  bz3_seq;
  logic [4:0]  cd3_seq;
  logic [31:0] ua_bz;
  logic [7:0]  cd3_win;
  logic        cd5_any;

  initial begin
    rst_n   = 1'b0;
    di      = 1'b0;
    stb     = 1'b0;
    dout    = 8'h00;
    pat     = 8'b1011_0010;
    so_seq  = '0;
    bz3_seq = '0;
    cd3_seq = '0;
    ua_bz   = '0;
    cd3_win = '0;
    cd5_any = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int e = 1; e <= 29; e++) begin
      step((e <= 8) ? pat[8-e] : 1'b0, e == 9, 8'h5A);
      if (e >= 9 && e <= 16) so_seq[16-e] = so0;
      if (e >= 9 && e <= 13) begin
        bz3_seq[13-e] = bz3;
        cd3_seq[13-e] = cd3;
      end
      ua_bz[e] = bza;
      if (e == 7) chk("ua.din_pre_load", 32'(dina), 32'h00);
      if (e == 8) chk("ua.din_first_load", 32'(dina), 32'h59);
      if (e == 9) chk("u0.din_stb", 32'(din0), 32'hB2);
    end
    chk("u0.do_stream", 32'(so_seq), 32'h5A);
    chk("u3.busy_window", 32'(bz3_seq), 32'b11100);
    chk("u3.cap_done_window", 32'(cd3_seq), 32'b00010);
    chk("ua.load_edges", ua_bz, 32'h0303_0300);

    for (int e = 30; e <= 49; e++) begin
      step(1'b0, e == 30 || e == 32 || e == 40,
           (e < 40) ? 8'h07 : 8'h03);
      if (e >= 30 && e <= 37) cd3_win[e-30] = cd3;
`ifdef SHR_PARITY_EN
      if (e == 30) chk("u0.par_07", 32'(pr0), 32'h1);
      if (e == 40) chk("u0.par_03", 32'(pr0), 32'h0);
      if (e == 36) chk("u3.par_07", 32'(pr3), 32'h1);
      if (e == 44) chk("u3.par_03", 32'(pr3), 32'h0);
`endif
    end
    chk("u3.restart_single_cap", 32'(cd3_win), 32'h20);

    for (int e = 50; e <= 52; e++)
      step(e[0], e == 50, 8'hC3);
    chk("u5.busy_before_reset", 32'(bz5), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("u5.busy_in_reset", 32'(bz5), 32'h0);
    chk("u5.din_in_reset", 32'(din5), 32'h00);
    chk("u5.do_in_reset", 32'(so5), 32'h0);
    chk("u5.cap_done_in_reset", 32'(cd5), 32'h0);
    chk("u0.din_in_reset", 32'(din0), 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int e = 1; e <= 20; e++) begin
      step(e % 3 == 0, 1'b0, 8'hFF);
      cd5_any = cd5_any | cd5;
      if (e == 7) chk("ua.busy_post_rst_7", 32'(bza), 32'h0);
      if (e == 8) chk("ua.busy_post_rst_8", 32'(bza), 32'h1);
    end
    chk("u5.no_cap_after_reset", 32'(cd5_any), 32'h0);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
